// File: rtl/imm_gen_pipe.sv
// Buffered RISC-V immediate generator: I/S/B/J/U decode into a DEPTH-entry output FIFO.
// Optional: define IMM_GEN_ZIMM_EN to decode imm_src 101 as a zero-extended CSR zimm.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_FW = PTR_W + 1;
    localparam logic [CNT_FW-1:0] DEPTH_C = CNT_FW'(DEPTH);

    typedef enum logic [2:0] {
        SRC_I = 3'b000,
        SRC_S = 3'b001,
        SRC_B = 3'b010,
        SRC_J = 3'b011,
        SRC_U = 3'b100,
        SRC_Z = 3'b101
    } imm_src_e;

    logic [31:0]       imm32;
    logic [XLEN-1:0]   dec_imm;
    logic              dec_illegal;
    logic [31:0]       sign;
    logic              unused_opcode;

    logic [XLEN-1:0]   mem_imm [DEPTH];
    logic              mem_ill [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_FW-1:0] count;
    logic              push;
    logic              pop;

    assign unused_opcode = ^instr[6:0];

    // Every format is built as a 32-bit value whose bit 31 carries the fill bit,
    // so one signed widening produces the XLEN result for both widths.
    always_comb begin
        sign        = {32{instr[31]}};
        imm32       = '0;
        dec_illegal = 1'b0;
        case (imm_src)
            SRC_I: imm32 = {sign[31:12], instr[31:20]};
            SRC_S: imm32 = {sign[31:12], instr[31:25], instr[11:7]};
            SRC_B: imm32 = {sign[31:13], instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            SRC_J: imm32 = {sign[31:21], instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            SRC_U: imm32 = {instr[31:12], 12'b0};
`ifdef IMM_GEN_ZIMM_EN
            SRC_Z: imm32 = {27'b0, instr[19:15]};
`endif
            default: begin
                imm32       = '0;
                dec_illegal = 1'b1;
            end
        endcase
    end

    assign dec_imm = XLEN'($signed(imm32));

    assign in_ready  = (count < DEPTH_C);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left unreset; out_valid gates what is visible.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_imm[wr_ptr] <= dec_imm;
            mem_ill[wr_ptr] <= dec_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (push && dec_illegal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

    assign out_imm     = out_valid ? mem_imm[rd_ptr] : '0;
    assign out_illegal = out_valid ? mem_ill[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: a 64-bit/CNT_W=2 and a 32-bit/CNT_W=8 instance share stimulus.
// Expected immediates are held as 64-bit values; the 32-bit instance checks the low half.
module tb_imm_gen_pipe;

    localparam int DEPTH = 2;

    bit          clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  imm_src;
    logic        out_ready;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [1:0]  illegal_cnt64;
    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32;
    logic [7:0]  illegal_cnt32;

    typedef struct {
        logic [63:0] imm;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   model_cnt = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH), .CNT_W(2)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .imm_src(imm_src), .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_illegal(out_illegal64), .illegal_cnt(illegal_cnt64)
    );

    imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .imm_src(imm_src), .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_illegal(out_illegal32), .illegal_cnt(illegal_cnt32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Monitor: samples at negedge; the model pops when the DUT will pop at the next posedge.
    always @(negedge clk) begin
        exp_t e;
        logic exp_v;
        if (rst_n === 1'b1) begin
            exp_v = (sb.size() != 0);
            chk("out_valid64", out_valid64, exp_v);
            chk("out_valid32", out_valid32, exp_v);
            chk("in_ready64", in_ready64, sb.size() < DEPTH);
            chk("in_ready32", in_ready32, sb.size() < DEPTH);
            chk("illegal_cnt64", illegal_cnt64, (model_cnt > 3) ? 3 : model_cnt);
            chk("illegal_cnt32", illegal_cnt32, (model_cnt > 255) ? 255 : model_cnt);
            if (exp_v) begin
                e = sb[0];
                chk("out_imm64", out_imm64, e.imm);
                chk("out_imm32", out_imm32, e.imm[31:0]);
                chk("out_illegal64", out_illegal64, e.ill);
                chk("out_illegal32", out_illegal32, e.ill);
                if (out_ready) void'(sb.pop_front());
            end else begin
                chk("idle_imm64", out_imm64, 64'd0);
                chk("idle_imm32", out_imm32, 64'd0);
                chk("idle_ill64", out_illegal64, 1'b0);
                chk("idle_ill32", out_illegal32, 1'b0);
            end
        end
    end

    // Holds the request until accepted (bounded); records expectations at the accepting edge.
    task automatic push(input logic [31:0] ins, input logic [2:0] src,
                        input logic [63:0] eimm, input logic eill);
        logic acc;
        int   t;
        acc = 1'b0;
        t = 0;
        in_valid = 1'b1;
        instr    = ins;
        imm_src  = src;
        do begin
            @(negedge clk);
            acc = in_ready64 && rst_n;
            @(posedge clk);
            if (acc) begin
                sb.push_back('{imm: eimm, ill: eill});
                if (eill) model_cnt++;
            end
            #1;
            t++;
        end while (!acc && t < 20);
        in_valid = 1'b0;
        n_cmp++;
        assert (acc) else begin
            n_err++;
            $error("FAIL push_timeout observed=%0d expected=1", acc);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        n_cmp++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL drain_timeout observed=%0d expected=0", sb.size());
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        imm_src   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single push: head appears one cycle after the push edge
        push(32'hFFF00093, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        drain();

        // Negative and positive immediates of each format, back to back
        push(32'hFE512E23, 3'b001, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        push(32'hFE000EE3, 3'b010, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        push(32'hFFDFF06F, 3'b011, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        push(32'h800000B7, 3'b100, 64'hFFFF_FFFF_8000_0000, 1'b0);
        push(32'h00112423, 3'b001, 64'd8, 1'b0);
        push(32'h00208463, 3'b010, 64'd8, 1'b0);
        push(32'h0080006F, 3'b011, 64'd8, 1'b0);
        push(32'h12345037, 3'b100, 64'h0000_0000_1234_5000, 1'b0);
        push(32'h7FF00093, 3'b000, 64'd2047, 1'b0);
        drain();

        // Fill with consumer stalled, hold third request, then release
        out_ready = 1'b0;
        push(32'h00100093, 3'b000, 64'd1, 1'b0);
        push(32'h00200093, 3'b000, 64'd2, 1'b0);
        in_valid = 1'b1;
        instr    = 32'h00300093;
        imm_src  = 3'b000;
        repeat (2) begin
            @(negedge clk);
            chk("full_in_ready", in_ready64, 1'b0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        push(32'h00300093, 3'b000, 64'd3, 1'b0);
        drain();

        // Reserved codes and counter saturation (CNT_W=2 saturates at 3)
        push(32'hDEADBEEF, 3'b110, 64'd0, 1'b1);
        drain();
        push(32'h12345678, 3'b111, 64'd0, 1'b1);
        push(32'hFFFFFFFF, 3'b110, 64'd0, 1'b1);
        push(32'h00000000, 3'b110, 64'd0, 1'b1);
        push(32'hA5A5A5A5, 3'b111, 64'd0, 1'b1);
        drain();
        chk("sat_cnt64", illegal_cnt64, 2'd3);
        chk("sat_cnt32", illegal_cnt32, 8'd5);

        // CSR zimm, instr[19:15] = 5'b11111
`ifdef IMM_GEN_ZIMM_EN
        push(32'h000F8073, 3'b101, 64'd31, 1'b0);
`else
        push(32'h000F8073, 3'b101, 64'd0, 1'b1);
`endif
        drain();

        // Reset with two entries buffered and a push attempted in the reset cycle
        out_ready = 1'b0;
        push(32'h00500093, 3'b000, 64'd5, 1'b0);
        push(32'h00600093, 3'b110, 64'd0, 1'b1);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        instr    = 32'h00700093;
        imm_src  = 3'b000;
        @(posedge clk);
        sb.delete();
        model_cnt = 0;
        #1;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid64, 1'b0);
        chk("rst_in_ready", in_ready64, 1'b1);
        chk("rst_illegal_cnt", illegal_cnt64, 2'd0);
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;
        push(32'hFFF00093, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        drain();
        repeat (2) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
